// File: rtl/exunit_ldst_sb.sv
// Load/store execution unit: EA generation, store buffer with youngest-match load
// forwarding, in-order drain of committed stores, and spectag kill/clear handling.
module exunit_ldst_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int RRF_W     = 6,
  parameter int SPECTAG_W = 5,
  parameter int SB_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue,
  output logic                        ready,
  input  logic                        dstval,
  input  logic [DATA_W-1:0]           ex_src1,
  input  logic [DATA_W-1:0]           ex_src2,
  input  logic [DATA_W-1:0]           imm,
  input  logic [RRF_W-1:0]            rrftag,
  input  logic                        specbit,
  input  logic [SPECTAG_W-1:0]        spectag,
  input  logic                        prmiss,
  input  logic                        prsuccess,
  input  logic [SPECTAG_W-1:0]        spectagfix,
  input  logic                        st_commit,
  output logic [ADDR_W-1:0]           ldaddr,
  input  logic [DATA_W-1:0]           lddatamem,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_waddr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [DATA_W-1:0]           result,
  output logic                        rrf_we,
  output logic                        rob_we,
  output logic [RRF_W-1:0]            wrrftag,
  output logic [$clog2(SB_DEPTH):0]   sb_count
);
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  function automatic logic [ADDR_W-1:0] calc_ea(input logic [DATA_W-1:0] base,
                                                input logic [DATA_W-1:0] ofs);
    logic [DATA_W-1:0] sum;
    sum = base + ofs;
    return ADDR_W'(sum);
  endfunction

  function automatic logic is_killed(input logic spec, input logic [SPECTAG_W-1:0] tag,
                                     input logic miss, input logic [SPECTAG_W-1:0] fix);
    return miss & spec & (|(tag & fix));
  endfunction

  function automatic logic [SPECTAG_W-1:0] clr_tag(input logic [SPECTAG_W-1:0] tag,
                                                  input logic succ,
                                                  input logic [SPECTAG_W-1:0] fix);
    return succ ? (tag & ~fix) : tag;
  endfunction

  logic                 vld_p1, ld_p1, spec_p1;
  logic [ADDR_W-1:0]    ea_p1;
  logic [DATA_W-1:0]    sdata_p1;
  logic [RRF_W-1:0]     rtag_p1;
  logic [SPECTAG_W-1:0] stag_p1;
  logic                 vld_p2, ld_p2, spec_p2, hit_p2;
  logic [DATA_W-1:0]    fwd_p2;
  logic [RRF_W-1:0]     rtag_p2;
  logic [SPECTAG_W-1:0] stag_p2;

  logic [ADDR_W-1:0]    sb_addr [SB_DEPTH];
  logic [DATA_W-1:0]    sb_data [SB_DEPTH];
  logic [SPECTAG_W-1:0] sb_stag [SB_DEPTH];
  logic                 sb_spec [SB_DEPTH];
  logic                 sb_cmt  [SB_DEPTH];
  logic [PTR_W-1:0]     head, tail, tail_base, cmt_idx, idx;
  logic [CNT_W-1:0]     count, nkill;
  logic [CNT_W:0]       occ;
  logic                 hit, cmt_found, drain;
  logic [DATA_W-1:0]    fwd;

  logic                 kill_in, accept, kill_p1, kill_p2, enq;
  logic [SPECTAG_W-1:0] in_stag_c, p1_stag_c;
  logic                 in_spec_c, p1_spec_c;

  assign in_stag_c = clr_tag(spectag, prsuccess, spectagfix);
  assign in_spec_c = specbit & (|in_stag_c);
  assign p1_stag_c = clr_tag(stag_p1, prsuccess, spectagfix);
  assign p1_spec_c = spec_p1 & (|p1_stag_c);

  assign kill_in = is_killed(specbit, spectag, prmiss, spectagfix);
  assign kill_p1 = is_killed(spec_p1, stag_p1, prmiss, spectagfix);
  assign kill_p2 = is_killed(spec_p2, stag_p2, prmiss, spectagfix);
  assign accept  = issue & ready & ~kill_in;
  assign enq     = vld_p1 & ~ld_p1 & ~kill_p1;

  // A store sitting in stage A already owns a slot; anything issued now lands a cycle later.
  assign occ   = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1 & ~ld_p1};
  assign ready = occ < (CNT_W + 1)'(SB_DEPTH);

  // Stage A: operand latch and EA
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      ea_p1  <= '0;
    end else begin
      vld_p1 <= accept;
      if (accept) ea_p1 <= calc_ea(ex_src1, imm);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ld_p1    <= dstval;
      sdata_p1 <= ex_src2;
      rtag_p1  <= rrftag;
      spec_p1  <= in_spec_c;
      stag_p1  <= in_stag_c;
    end
  end

  // Stage B: writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2  <= 1'b0;
      rtag_p2 <= '0;
    end else begin
      vld_p2 <= vld_p1 & ~kill_p1;
      if (vld_p1) rtag_p2 <= rtag_p1;
    end
  end

  always_ff @(posedge clk) begin
    ld_p2   <= ld_p1;
    hit_p2  <= hit;
    fwd_p2  <= fwd;
    spec_p2 <= p1_spec_c;
    stag_p2 <= p1_stag_c;
  end

  assign ldaddr  = ea_p1;
  assign rob_we  = vld_p2 & ~kill_p2;
  assign rrf_we  = rob_we & ld_p2;
  assign wrrftag = rtag_p2;
  assign result  = (vld_p2 & ld_p2) ? (hit_p2 ? fwd_p2 : lddatamem) : '0;

  // Walk oldest to youngest so the last address match is the youngest store.
  always_comb begin
    hit       = 1'b0;
    fwd       = '0;
    cmt_found = 1'b0;
    cmt_idx   = head;
    nkill     = '0;
    idx       = head;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        if (sb_addr[idx] == ea_p1) begin
          hit = 1'b1;
          fwd = sb_data[idx];
        end
        if (!sb_cmt[idx]) begin
          if (!cmt_found) begin
            cmt_found = 1'b1;
            cmt_idx   = idx;
          end
          if (is_killed(sb_spec[idx], sb_stag[idx], prmiss, spectagfix)) nkill = nkill + CNT_W'(1);
        end
      end
    end
  end

  // Killed entries are the youngest run, so rolling the tail back by their number frees them.
  assign tail_base = tail - nkill[PTR_W-1:0];
  assign drain     = (count != '0) & sb_cmt[head];
  assign mem_we    = drain;
  assign mem_waddr = drain ? sb_addr[head] : '0;
  assign mem_wdata = drain ? sb_data[head] : '0;
  assign sb_count  = count;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SB_DEPTH; i++) sb_cmt[i] <= 1'b0;
    end else begin
      if (prsuccess) begin
        for (int i = 0; i < SB_DEPTH; i++) begin
          sb_stag[i] <= sb_stag[i] & ~spectagfix;
          sb_spec[i] <= sb_spec[i] & (|(sb_stag[i] & ~spectagfix));
        end
      end
      if (st_commit && cmt_found) sb_cmt[cmt_idx] <= 1'b1;
      if (enq) begin
        sb_spec[tail_base] <= p1_spec_c;
        sb_stag[tail_base] <= p1_stag_c;
        sb_cmt[tail_base]  <= 1'b0;
      end
      if (drain) head <= head + PTR_W'(1);
      tail  <= tail_base + PTR_W'(enq);
      count <= count - nkill - CNT_W'(drain) + CNT_W'(enq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      sb_addr[tail_base] <= ea_p1;
      sb_data[tail_base] <= sdata_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && st_commit) assert (cmt_found);
  end
endmodule

// File: tb/tb_exunit_ldst_sb.sv
// Scenario bench for exunit_ldst_sb: each task pushes expected writebacks/drains onto
// scoreboard queues that a negedge monitor pops, plus its own direct output checks.
`timescale 1ns/1ps
module tb_exunit_ldst_sb;
  localparam int DATA_W = 32, ADDR_W = 32, RRF_W = 6, SPECTAG_W = 5, SB_DEPTH = 4;

  logic clk = 1'b0;
  logic reset, issue, ready, dstval, specbit, prmiss, prsuccess, st_commit;
  logic [DATA_W-1:0] ex_src1, ex_src2, imm, lddatamem, mem_wdata, result;
  logic [RRF_W-1:0] rrftag, wrrftag;
  logic [SPECTAG_W-1:0] spectag, spectagfix;
  logic [ADDR_W-1:0] ldaddr, mem_waddr;
  logic mem_we, rrf_we, rob_we;
  logic [$clog2(SB_DEPTH):0] sb_count;

  typedef struct { logic ld; logic [RRF_W-1:0] tag; logic [DATA_W-1:0] res; } wb_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_t;
  wb_t exp_wb[$];
  wr_t exp_wr[$];
  wb_t mon_wb;
  wr_t mon_wr;
  int n_cmp = 0, n_bad = 0;

  exunit_ldst_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RRF_W(RRF_W),
                   .SPECTAG_W(SPECTAG_W), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset), .issue(issue), .ready(ready), .dstval(dstval),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .imm(imm), .rrftag(rrftag),
    .specbit(specbit), .spectag(spectag), .prmiss(prmiss), .prsuccess(prsuccess),
    .spectagfix(spectagfix), .st_commit(st_commit), .ldaddr(ldaddr),
    .lddatamem(lddatamem), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .result(result), .rrf_we(rrf_we), .rob_we(rob_we),
    .wrrftag(wrrftag), .sb_count(sb_count));

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_val(input logic [ADDR_W-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) lddatamem <= mem_val(ldaddr);

  always @(negedge clk) begin
    if (rob_we) begin
      n_cmp++;
      if (exp_wb.size() == 0) begin
        n_bad++;
        $display("FAIL wb_unexpected: rob_we=1 tag=%0d, required no writeback", wrrftag);
      end else begin
        mon_wb = exp_wb.pop_front();
        if (rrf_we !== mon_wb.ld || wrrftag !== mon_wb.tag || (mon_wb.ld && result !== mon_wb.res)) begin
          n_bad++;
          $display("FAIL wb: rrf_we=%0b tag=%0d result=%h, required rrf_we=%0b tag=%0d result=%h",
                   rrf_we, wrrftag, result, mon_wb.ld, mon_wb.tag, mon_wb.res);
        end
      end
    end else if (rrf_we) begin
      n_cmp++; n_bad++;
      $display("FAIL rrf_we_alone: rrf_we=1 rob_we=0, required both 0");
    end
    if (mem_we) begin
      n_cmp++;
      if (exp_wr.size() == 0) begin
        n_bad++;
        $display("FAIL drain_unexpected: addr=%h data=%h, required no drain", mem_waddr, mem_wdata);
      end else begin
        mon_wr = exp_wr.pop_front();
        if (mem_waddr !== mon_wr.addr || mem_wdata !== mon_wr.data) begin
          n_bad++;
          $display("FAIL drain: addr=%h data=%h, required addr=%h data=%h",
                   mem_waddr, mem_wdata, mon_wr.addr, mon_wr.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_op(input logic ld, input logic [DATA_W-1:0] base, input logic [DATA_W-1:0] ofs,
                          input logic [DATA_W-1:0] data, input logic [RRF_W-1:0] tag,
                          input logic sp, input logic [SPECTAG_W-1:0] st);
    issue = 1'b1; dstval = ld; ex_src1 = base; imm = ofs; ex_src2 = data;
    rrftag = tag; specbit = sp; spectag = st;
    step();
    issue = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_cmp++;
    if (ready !== 1'b1 || sb_count !== 3'd0) begin
      n_bad++; $display("FAIL reset_ready_count: ready=%0b count=%0d, required 1 0", ready, sb_count);
    end
    n_cmp++;
    if ({mem_we, rrf_we, rob_we} !== 3'b000) begin
      n_bad++; $display("FAIL reset_strobes: %b, required 000", {mem_we, rrf_we, rob_we});
    end
    n_cmp++;
    if (result !== '0 || wrrftag !== '0 || ldaddr !== '0 || mem_waddr !== '0 || mem_wdata !== '0) begin
      n_bad++; $display("FAIL reset_data: result=%h tag=%0d ldaddr=%h waddr=%h wdata=%h, required all 0",
                        result, wrrftag, ldaddr, mem_waddr, mem_wdata);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_load();
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %0b, required 1", ready); end
    exp_wb.push_back('{ld: 1'b1, tag: 6'd3, res: mem_val(32'h110)});
    issue_op(1'b1, 32'h100, 32'h10, 32'h0, 6'd3, 1'b0, 5'd0);
    n_cmp++;
    if (ldaddr !== 32'h110) begin n_bad++; $display("FAIL load_ldaddr: got %h, required 00000110", ldaddr); end
    step();
    n_cmp++;
    if (rrf_we !== 1'b1 || result !== mem_val(32'h110)) begin
      n_bad++; $display("FAIL load_result: rrf_we=%0b result=%h, required 1 %h", rrf_we, result, mem_val(32'h110));
    end
    step();
  endtask

  task automatic test_forward();
    exp_wb.push_back('{ld: 1'b0, tag: 6'd4, res: '0});
    exp_wb.push_back('{ld: 1'b1, tag: 6'd5, res: 32'hAA});
    issue_op(1'b0, 32'h100, 32'h10, 32'hAA, 6'd4, 1'b0, 5'd0);
    issue_op(1'b1, 32'h108, 32'h8, 32'h0, 6'd5, 1'b0, 5'd0);
    n_cmp++;
    if (mem_we !== 1'b0) begin n_bad++; $display("FAIL fwd_no_drain_a: mem_we=%0b, required 0", mem_we); end
    step();
    n_cmp++;
    if (result !== 32'hAA || mem_we !== 1'b0 || sb_count !== 3'd1) begin
      n_bad++; $display("FAIL fwd_result: result=%h mem_we=%0b count=%0d, required 000000aa 0 1",
                        result, mem_we, sb_count);
    end
    exp_wr.push_back('{addr: 32'h110, data: 32'hAA});
    st_commit = 1'b1; step(); st_commit = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1 || mem_waddr !== 32'h110) begin
      n_bad++; $display("FAIL fwd_drain: mem_we=%0b addr=%h, required 1 00000110", mem_we, mem_waddr);
    end
    step(); step();
    n_cmp++;
    if (sb_count !== 3'd0) begin n_bad++; $display("FAIL fwd_empty: count=%0d, required 0", sb_count); end
  endtask

  task automatic test_youngest();
    exp_wb.push_back('{ld: 1'b0, tag: 6'd10, res: '0});
    exp_wb.push_back('{ld: 1'b0, tag: 6'd11, res: '0});
    exp_wb.push_back('{ld: 1'b1, tag: 6'd12, res: 32'h2});
    issue_op(1'b0, 32'h20, 32'h0, 32'h1, 6'd10, 1'b0, 5'd0);
    issue_op(1'b0, 32'h18, 32'h8, 32'h2, 6'd11, 1'b0, 5'd0);
    issue_op(1'b1, 32'h20, 32'h0, 32'h0, 6'd12, 1'b0, 5'd0);
    step();
    n_cmp++;
    if (sb_count !== 3'd2) begin n_bad++; $display("FAIL young_count: count=%0d, required 2", sb_count); end
    exp_wr.push_back('{addr: 32'h20, data: 32'h1});
    exp_wr.push_back('{addr: 32'h20, data: 32'h2});
    st_commit = 1'b1; step(); step(); st_commit = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (sb_count !== 3'd0) begin n_bad++; $display("FAIL young_empty: count=%0d, required 0", sb_count); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < SB_DEPTH; i++) begin
      exp_wb.push_back('{ld: 1'b0, tag: RRF_W'(16 + i), res: '0});
      issue_op(1'b0, DATA_W'(32'h40 + i), 32'h0, DATA_W'(32'h100 + i), RRF_W'(16 + i), 1'b0, 5'd0);
    end
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_a: ready=%0b, required 0", ready); end
    step();
    n_cmp++;
    if (ready !== 1'b0 || sb_count !== 3'd4) begin
      n_bad++; $display("FAIL full_state: ready=%0b count=%0d, required 0 4", ready, sb_count);
    end
    exp_wr.push_back('{addr: 32'h40, data: 32'h100});
    st_commit = 1'b1; step(); st_commit = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin n_bad++; $display("FAIL full_ready_drain: ready=%0b, required 0", ready); end
    step();
    n_cmp++;
    if (ready !== 1'b1 || sb_count !== 3'd3) begin
      n_bad++; $display("FAIL full_reopen: ready=%0b count=%0d, required 1 3", ready, sb_count);
    end
    exp_wb.push_back('{ld: 1'b0, tag: 6'd20, res: '0});
    issue_op(1'b0, 32'h44, 32'h0, 32'h104, 6'd20, 1'b0, 5'd0);
    exp_wr.push_back('{addr: 32'h41, data: 32'h101});
    st_commit = 1'b1; step(); st_commit = 1'b0;
    step();
    n_cmp++;
    if (ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: ready=%0b, required 1", ready); end
    exp_wb.push_back('{ld: 1'b1, tag: 6'd21, res: 32'h104});
    issue_op(1'b1, 32'h40, 32'h4, 32'h0, 6'd21, 1'b0, 5'd0);
    exp_wr.push_back('{addr: 32'h42, data: 32'h102});
    exp_wr.push_back('{addr: 32'h43, data: 32'h103});
    exp_wr.push_back('{addr: 32'h44, data: 32'h104});
    st_commit = 1'b1; step(); step(); step(); st_commit = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (sb_count !== 3'd0) begin n_bad++; $display("FAIL wrap_empty: count=%0d, required 0", sb_count); end
  endtask

  task automatic test_kill_sb();
    exp_wb.push_back('{ld: 1'b0, tag: 6'd24, res: '0});
    issue_op(1'b0, 32'h60, 32'h0, 32'h11, 6'd24, 1'b1, 5'b00001);
    issue_op(1'b0, 32'h61, 32'h0, 32'h22, 6'd25, 1'b1, 5'b00010);
    step();
    n_cmp++;
    if (sb_count !== 3'd2) begin n_bad++; $display("FAIL kill_pre_count: count=%0d, required 2", sb_count); end
    prmiss = 1'b1; spectagfix = 5'b00010; #1;
    n_cmp++;
    if (rob_we !== 1'b0) begin n_bad++; $display("FAIL kill_store_rob: rob_we=%0b, required 0", rob_we); end
    step(); prmiss = 1'b0;
    n_cmp++;
    if (sb_count !== 3'd1) begin n_bad++; $display("FAIL kill_post_count: count=%0d, required 1", sb_count); end
    exp_wb.push_back('{ld: 1'b0, tag: 6'd26, res: '0});
    issue_op(1'b0, 32'h62, 32'h0, 32'h33, 6'd26, 1'b1, 5'b00100);
    prsuccess = 1'b1; spectagfix = 5'b00101; step(); prsuccess = 1'b0;
    prmiss = 1'b1; #1;
    n_cmp++;
    if (rob_we !== 1'b1) begin n_bad++; $display("FAIL clear_survives: rob_we=%0b, required 1", rob_we); end
    step(); prmiss = 1'b0;
    n_cmp++;
    if (sb_count !== 3'd2) begin n_bad++; $display("FAIL clear_count: count=%0d, required 2", sb_count); end
    exp_wr.push_back('{addr: 32'h60, data: 32'h11});
    exp_wr.push_back('{addr: 32'h62, data: 32'h33});
    st_commit = 1'b1; step(); step(); st_commit = 1'b0;
    step(); step(); step();
    n_cmp++;
    if (sb_count !== 3'd0) begin n_bad++; $display("FAIL kill_empty: count=%0d, required 0", sb_count); end
  endtask

  task automatic test_kill_load_reset();
    issue_op(1'b1, 32'h80, 32'h0, 32'h0, 6'd30, 1'b1, 5'b01000);
    step();
    prmiss = 1'b1; spectagfix = 5'b01000;
    issue = 1'b1; dstval = 1'b1; ex_src1 = 32'h84; imm = 32'h0; rrftag = 6'd31;
    specbit = 1'b1; spectag = 5'b01000;
    #1;
    n_cmp++;
    if ({rob_we, rrf_we} !== 2'b00) begin
      n_bad++; $display("FAIL kill_load: rob_we/rrf_we=%b, required 00", {rob_we, rrf_we});
    end
    step(); prmiss = 1'b0; issue = 1'b0; specbit = 1'b0;
    step();
    n_cmp++;
    if (rob_we !== 1'b0) begin n_bad++; $display("FAIL drop_issue: rob_we=%0b, required 0", rob_we); end
    exp_wb.push_back('{ld: 1'b0, tag: 6'd32, res: '0});
    issue_op(1'b0, 32'h90, 32'h0, 32'h55, 6'd32, 1'b0, 5'd0);
    step();
    exp_wr.push_back('{addr: 32'h90, data: 32'h55});
    st_commit = 1'b1; step(); st_commit = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rst_drain_on: mem_we=%0b, required 1", mem_we); end
    reset = 1'b1; step();
    n_cmp++;
    if (mem_we !== 1'b0 || sb_count !== 3'd0 || ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_mid_drain: mem_we=%0b count=%0d ready=%0b, required 0 0 1",
                        mem_we, sb_count, ready);
    end
    reset = 1'b0; step();
  endtask

  initial begin
    reset = 1'b1; issue = 1'b0; dstval = 1'b0; ex_src1 = '0; ex_src2 = '0; imm = '0;
    rrftag = '0; specbit = 1'b0; spectag = '0; prmiss = 1'b0; prsuccess = 1'b0;
    spectagfix = '0; st_commit = 1'b0;
    test_reset();
    test_load();
    test_forward();
    test_youngest();
    test_full_wrap();
    test_kill_sb();
    test_kill_load_reset();
    step(); step();
    n_cmp++;
    if (exp_wb.size() != 0) begin
      n_bad++; $display("FAIL wb_missing: %0d writebacks outstanding, required 0", exp_wb.size());
    end
    n_cmp++;
    if (exp_wr.size() != 0) begin
      n_bad++; $display("FAIL drain_missing: %0d drains outstanding, required 0", exp_wr.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
